// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state type and alignment check for dmem_ws.
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic {IDLE, BUSY} state_t;
   // Unlisted codes fall through to the word rule.
   function automatic logic misalign(input logic [2:0] f3, input logic [1:0] a);
      return (f3 == F3_B || f3 == F3_BU) ? 1'b0 :
             (f3 == F3_H || f3 == F3_HU) ? a[0] : (a != 2'b00);
   endfunction
endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt: merges sub-word store data into a word and extracts/extends load data.
module dmem_lane_fmt (
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] old_word,
   input  logic [31:0] wd,
   output logic [31:0] st_word,
   output logic [31:0] ld_val
);
   logic [4:0]  bsh, hsh;
   logic [31:0] mask, sdat, shifted;
   logic        is_b, is_h;
   always_comb begin
      is_b    = funct3[1:0] == 2'b00;
      is_h    = funct3[1:0] == 2'b01;
      bsh     = {addr_lo, 3'b000};
      hsh     = {addr_lo[1], 4'b0000};
      mask    = is_b ? 32'h0000_00FF << bsh : is_h ? 32'h0000_FFFF << hsh : 32'hFFFF_FFFF;
      sdat    = is_b ? wd << bsh : is_h ? wd << hsh : wd;
      st_word = (old_word & ~mask) | (sdat & mask);
      shifted = old_word >> bsh;
      ld_val  = is_b ? {{24{~funct3[2] & shifted[7]}}, shifted[7:0]} :
                is_h ? {{16{~funct3[2] & shifted[15]}}, shifted[15:0]} : old_word;
   end
endmodule

// File: rtl/dmem_ws.sv
// dmem_ws: word-organised data memory with sub-word access and a wait-state stall FSM.
module dmem_ws
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter int IDX_W       = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        stall,
   output logic        misaligned
);
   localparam logic [3:0] WC = 4'(WAIT_CYCLES);
   logic [31:0]      mem [DEPTH];
   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx;
   logic [31:0]      st_word, ld_val;
   logic             req, bad, complete, we;
   logic             addr_unused;
   assign addr_unused = ^addr[31:IDX_W+2];
   assign idx = addr[IDX_W+1:2];
   dmem_lane_fmt u_fmt (
      .funct3  (funct3),
      .addr_lo (addr[1:0]),
      .old_word(mem[idx]),
      .wd      (wd),
      .st_word (st_word),
      .ld_val  (ld_val)
   );
   always_comb begin
      req        = memread | memwrite;
      bad        = misalign(funct3, addr[1:0]);
      misaligned = state_q == IDLE && req && bad;
      complete   = state_q == BUSY ? cnt_q == 4'd0 && req : req && !bad && WC == 4'd0;
      stall      = state_q == BUSY ? cnt_q != 4'd0 : req && !bad && WC != 4'd0;
      we         = complete && memwrite;
      rd         = complete && memread && !memwrite ? ld_val : 32'h0;
      state_d    = state_q;
      cnt_d      = cnt_q;
      if (state_q == IDLE && req && !bad && WC != 4'd0) begin
         state_d = BUSY;
         cnt_d   = WC - 4'd1;
      end else if (state_q == BUSY) begin
         state_d = cnt_q == 4'd0 ? IDLE : BUSY;
         cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end
   // Contents survive reset; only an in-flight store is abandoned.
   always_ff @(posedge clk) begin
      if (!reset && we) mem[idx] <= st_word;
   end
endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: directed checks of dmem_ws with 2 wait states and with zero wait states.
module tb_dmem_ws;
   import dmem_pkg::*;
   logic        clk = 1'b0, reset = 1'b1;
   logic        memread, memwrite, memread0, memwrite0;
   logic [2:0]  funct3, funct30;
   logic [31:0] addr, wd, addr0, wd0, rd, rd0;
   logic        stall, misaligned, stall0, misaligned0;
   int          nvec = 0, nerr = 0;
   logic [31:0] rv;
   int          cyc;
   logic        early;
   always #5 clk = ~clk;
   dmem_ws #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .funct3(funct3),
      .addr(addr), .wd(wd), .rd(rd), .stall(stall), .misaligned(misaligned)
   );
   dmem_ws #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .memread(memread0), .memwrite(memwrite0), .funct3(funct30),
      .addr(addr0), .wd(wd0), .rd(rd0), .stall(stall0), .misaligned(misaligned0)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Holds a request until stall drops; reports completion rd, cycle count and any early rd.
   task automatic acc(input logic w, input logic r, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, output logic [31:0] v, output int n, output logic e);
      memwrite = w; memread = r; funct3 = f; addr = a; wd = d;
      n = 0; e = 1'b0; v = 'x;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (!stall) begin
            v = rd;
            break;
         end
         if (rd != 0) e = 1'b1;
      end
      @(posedge clk); #1;
      memwrite = 1'b0; memread = 1'b0;
   endtask
   task automatic acc0(input logic w, input logic r, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] v, output logic s);
      memwrite0 = w; memread0 = r; funct30 = f; addr0 = a; wd0 = d;
      @(negedge clk);
      v = rd0; s = stall0;
      @(posedge clk); #1;
      memwrite0 = 1'b0; memread0 = 1'b0;
   endtask
   initial begin
      logic s;
      memread = 0; memwrite = 0; funct3 = F3_W; addr = 0; wd = 0;
      memread0 = 0; memwrite0 = 0; funct30 = F3_W; addr0 = 0; wd0 = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_mis", {31'b0, misaligned}, 0);
      chk("rst_rd", rd, 0);
      @(posedge clk); #1; reset = 1'b0;
      acc(1, 0, F3_W, 32'h10, 32'hDEADBEEF, rv, cyc, early);
      chk("sw_cycles", cyc, 3);
      chk("sw_rd", rv, 0);
      acc(0, 1, F3_W, 32'h10, 0, rv, cyc, early);
      chk("lw_cycles", cyc, 3);
      chk("lw_early", {31'b0, early}, 0);
      chk("lw_rd", rv, 32'hDEADBEEF);
      acc(1, 0, F3_W, 32'h14, 32'h11223344, rv, cyc, early);
      acc(1, 0, F3_B, 32'h17, 32'h000000AA, rv, cyc, early);
      acc(0, 1, F3_W, 32'h14, 0, rv, cyc, early);
      chk("sb_word", rv, 32'hAA223344);
      acc(0, 1, F3_B, 32'h17, 0, rv, cyc, early);
      chk("lb", rv, 32'hFFFFFFAA);
      acc(0, 1, F3_BU, 32'h17, 0, rv, cyc, early);
      chk("lbu", rv, 32'h000000AA);
      acc(0, 1, F3_B, 32'h14, 0, rv, cyc, early);
      chk("lb_pos", rv, 32'h00000044);
      acc(1, 0, F3_W, 32'h18, 32'h7777BEEF, rv, cyc, early);
      acc(1, 0, F3_H, 32'h1A, 32'h00008001, rv, cyc, early);
      acc(0, 1, F3_H, 32'h1A, 0, rv, cyc, early);
      chk("lh", rv, 32'hFFFF8001);
      acc(0, 1, F3_HU, 32'h1A, 0, rv, cyc, early);
      chk("lhu", rv, 32'h00008001);
      acc(0, 1, F3_W, 32'h18, 0, rv, cyc, early);
      chk("sh_word", rv, 32'h8001BEEF);
      acc(1, 0, F3_W, 32'h04, 32'h55667788, rv, cyc, early);
      memread = 1; funct3 = F3_W; addr = 32'h06;
      @(negedge clk);
      chk("mis_lw", {31'b0, misaligned}, 1);
      chk("mis_lw_stall", {31'b0, stall}, 0);
      chk("mis_lw_rd", rd, 0);
      @(posedge clk); #1;
      memread = 0; memwrite = 1; funct3 = F3_H; addr = 32'h05; wd = 32'h0000FFFF;
      @(negedge clk);
      chk("mis_sh", {31'b0, misaligned}, 1);
      chk("mis_sh_stall", {31'b0, stall}, 0);
      @(posedge clk); #1;
      memwrite = 0;
      @(negedge clk);
      chk("mis_idle", {31'b0, stall}, 0);
      acc(0, 1, F3_W, 32'h04, 0, rv, cyc, early);
      chk("mis_nowrite", rv, 32'h55667788);
      acc(1, 0, F3_W, 32'h20, 32'hA5A5A5A5, rv, cyc, early);
      memwrite = 1; funct3 = F3_W; addr = 32'h20; wd = 32'h12345678;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("busy_stall", {31'b0, stall}, 1);
      @(posedge clk); #1;
      reset = 1'b0; memwrite = 0;
      @(negedge clk);
      chk("abort_stall", {31'b0, stall}, 0);
      acc(0, 1, F3_W, 32'h20, 0, rv, cyc, early);
      chk("abort_nowrite", rv, 32'hA5A5A5A5);
      acc0(1, 0, F3_W, 32'h400, 32'hCAFEF00D, rv, s);
      chk("ws0_sw_stall", {31'b0, s}, 0);
      acc0(0, 1, F3_W, 32'h000, 0, rv, s);
      chk("ws0_alias", rv, 32'hCAFEF00D);
      chk("ws0_lw_stall", {31'b0, s}, 0);
      acc0(0, 1, F3_HU, 32'h402, 0, rv, s);
      chk("ws0_lhu", rv, 32'h0000CAFE);
      acc0(0, 1, F3_B, 32'h401, 0, rv, s);
      chk("ws0_lb", rv, 32'hFFFFFFF0);
      acc0(1, 1, F3_W, 32'h08, 32'h0BADBEEF, rv, s);
      chk("ws0_both_rd", rv, 0);
      acc0(0, 1, F3_W, 32'h08, 0, rv, s);
      chk("ws0_both_wr", rv, 32'h0BADBEEF);
      memread0 = 1; funct30 = 3'b011; addr0 = 32'h02;
      @(negedge clk);
      chk("ws0_f3_011_mis", {31'b0, misaligned0}, 1);
      @(posedge clk); #1;
      memread0 = 0;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/dmem_ws.md
Name: dmem_ws

Overview:
- Parametrised successor to the single-cycle data memory. Word-organised array with byte/halfword/word loads and stores, sign/zero extension, and misalignment detection.
- A configurable wait-state counter models slower memory; a `stall` output freezes the pipeline's MEM stage while an access is in flight.
- Sits in the MEM stage and is driven by the memread/memwrite/funct3 controls from EX/MEM.

Parameters:
- DEPTH, 256: number of 32-bit words; power of two, >= 4.
- WAIT_CYCLES, 2: extra cycles per access, legal range 0..15; 0 gives single-cycle behaviour.
- IDX_W, $clog2(DEPTH): word-index width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- memread  in  1  load request.
- memwrite  in  1  store request.
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address.
- wd  in  32  store data; low bits are used for sub-word stores.
- rd  out  32  load result, already extended.
- stall  out  1  high means the MEM stage must hold all inputs stable.
- misaligned  out  1  request is misaligned; the access is dropped.

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset:
  - state goes to IDLE, the wait counter goes to 0, stall=0, misaligned=0, rd=0.
  - Memory contents are NOT cleared, including on reset mid-access.
- req = memread | memwrite. If both are high, the access is a write and rd=0.
- Index = addr[IDX_W+1:2]. Upper address bits are ignored, so addresses alias modulo DEPTH*4.
- Misaligned rule:
  - h/hu with addr[0]=1, or w with addr[1:0]!=0.
  - Output is combinational, asserted only in IDLE with req.
  - When asserted: no write, rd=0, stall=0, no state change.
- Unlisted funct3 codes (011/110/111) are treated as word accesses.
- FSM has two states, IDLE and BUSY; the counter cnt is 4 bits.
  - IDLE, no req: stall=0, rd=0.
  - IDLE, aligned req, WAIT_CYCLES=0: access completes this cycle. Read is combinational from the array; write commits at this edge; stall=0.
  - IDLE, aligned req, WAIT_CYCLES>0: stall=1, cnt <= WAIT_CYCLES-1, go to BUSY. Nothing is read or written yet.
  - BUSY, cnt!=0: stall=1, cnt decrements.
  - BUSY, cnt==0: stall=0, access completes as above, return to IDLE.
- Latency: WAIT_CYCLES+1 cycles per access, with stall high for exactly WAIT_CYCLES of them. Back-to-back requests are accepted in the cycle after completion.
- Inputs changing while stall=1 is a protocol violation. The block uses the values present in the completing cycle.
- Stores:
  - sb writes wd[7:0] into lane addr[1:0].
  - sh writes wd[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - sw writes all four lanes.
  - Unwritten lanes are preserved. Little-endian.
- Loads:
  - lb/lh sign-extend the selected byte or half.
  - lbu/lhu zero-extend.
  - lw returns the whole word.
  - rd=0 in every cycle that is not a completing read.
- Reset during BUSY aborts the access: no write, IDLE on the next cycle.

Decomposition:
- Package dmem_pkg holds:
  - F3_B, F3_H, F3_W, F3_BU, F3_HU localparams.
  - The state_t enum {IDLE, BUSY}.
  - The misalignment check as a function.
- One combinational sub-module, dmem_lane_fmt:
  - Inputs: funct3, addr[1:0], the old word, wd.
  - Outputs: the merged store word and the extended load value.

Test Plan:
1. WAIT_CYCLES=2: sw addr 0x10 wd 0xDEADBEEF -> stall 1,1,0 and the write commits on the 3rd edge. Then lw 0x10 -> stall 1,1,0 and rd=0xDEADBEEF in cycle 3, 0 before.
2. Word 0x14 = 0x11223344; sb 0x17 wd 0x000000AA -> word becomes 0xAA223344. lb 0x17 -> 0xFFFFFFAA; lbu 0x17 -> 0x000000AA.
3. sh 0x1A wd 0x00008001 -> lh 0x1A gives 0xFFFF8001, lhu 0x1A gives 0x00008001, and the low half of word 0x18 is unchanged.
4. lw 0x06, then sh 0x05 -> misaligned=1, stall=0, rd=0, memory unchanged, FSM stays in IDLE.
5. sw 0x20 wd 0x12345678 with reset asserted in its first BUSY cycle -> stall=0 the next cycle. A later lw 0x20 returns the prior contents.
6. WAIT_CYCLES=0, DEPTH=256: sw/lw every cycle, stall never rises. sw 0x400 wd 0xCAFEF00D, then lw 0x000 -> 0xCAFEF00D (alias). memread+memwrite together -> write performed, rd=0.
